// File: rtl/rc4_phase_sequencer.sv
// Top-level RC4 key-search sequencer: walks enabled worker phases, retries keys until success or range end.
// Optional per-phase watchdog compiled in with `define PHASE_WATCHDOG_EN.
module rc4_phase_sequencer #(
    parameter int                    NUM_PHASES     = 5,
    parameter logic [NUM_PHASES-1:0] PHASE_MASK     = '1,
    parameter int                    KEY_WIDTH      = 24,
    parameter logic [KEY_WIDTH-1:0]  KEY_END        = 24'h3FFFFF,
    parameter int                    TIMEOUT_CYCLES = 65535,
    localparam int                   PW             = $clog2(NUM_PHASES)
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  restart,
    input  logic [KEY_WIDTH-1:0]  key_start,
    input  logic [NUM_PHASES-1:0] phase_done,
    input  logic                  decrypt_valid,
    output logic                  reset_all,
    output logic [NUM_PHASES-1:0] phase_start,
    output logic [PW-1:0]         phase_idx,
    output logic [KEY_WIDTH-1:0]  candidate_key,
    output logic                  busy,
    output logic                  key_found,
    output logic                  search_exhausted,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LAUNCH, RUN, NEXT_KEY, FOUND, EXHAUSTED, TIMEOUT
    } state_t;

    function automatic logic [PW-1:0] first_enabled();
        logic [PW-1:0] f;
        f = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--)
            if (PHASE_MASK[i]) f = PW'(i);
        return f;
    endfunction

    function automatic logic [PW-1:0] last_enabled();
        logic [PW-1:0] l;
        l = '0;
        for (int i = 0; i < NUM_PHASES; i++)
            if (PHASE_MASK[i]) l = PW'(i);
        return l;
    endfunction

    // Lowest enabled index above cur; masked phases are never visited.
    function automatic logic [PW-1:0] next_enabled(input logic [PW-1:0] cur);
        logic [PW-1:0] n;
        n = cur;
        for (int i = NUM_PHASES - 1; i >= 0; i--)
            if (PHASE_MASK[i] && i > int'(cur)) n = PW'(i);
        return n;
    endfunction

    localparam logic [PW-1:0] FIRST_PH = first_enabled();
    localparam logic [PW-1:0] LAST_PH  = last_enabled();

    state_t                 state, state_next;
    logic [PW-1:0]          idx_next;
    logic [KEY_WIDTH-1:0]   key_next;
    logic                   cur_done;

    assign cur_done = phase_done[phase_idx];

`ifdef PHASE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_trip;

    assign wd_trip = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            wd_cnt <= '0;
        else if (state == LAUNCH)
            wd_cnt <= '0;
        else if (state == RUN)
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= IDLE;
            phase_idx     <= '0;
            candidate_key <= '0;
        end else begin
            state         <= state_next;
            phase_idx     <= idx_next;
            candidate_key <= key_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = phase_idx;
        key_next   = candidate_key;
        case (state)
            CLEAR: begin
                key_next   = key_start;
                idx_next   = FIRST_PH;
                state_next = LAUNCH;
            end
            LAUNCH: state_next = RUN;
            RUN: begin
                if (cur_done) begin
                    if (phase_idx != LAST_PH) begin
                        idx_next   = next_enabled(phase_idx);
                        state_next = LAUNCH;
                    end else if (decrypt_valid)
                        state_next = FOUND;
                    // >= so a start key beyond the range still gets exactly one attempt
                    else if (candidate_key >= KEY_END)
                        state_next = EXHAUSTED;
                    else
                        state_next = NEXT_KEY;
                end
`ifdef PHASE_WATCHDOG_EN
                else if (wd_trip)
                    state_next = TIMEOUT;
`endif
            end
            NEXT_KEY: begin
                key_next   = candidate_key + 1'b1;
                idx_next   = FIRST_PH;
                state_next = LAUNCH;
            end
            default: ;
        endcase
        if (restart)
            state_next = CLEAR;
    end

    always_comb begin
        phase_start = '0;
        if (state == LAUNCH || state == RUN)
            phase_start[phase_idx] = 1'b1;
        reset_all        = (state == CLEAR) || (state == NEXT_KEY);
        busy             = (state == CLEAR) || (state == LAUNCH) ||
                           (state == RUN)   || (state == NEXT_KEY);
        key_found        = (state == FOUND);
        search_exhausted = (state == EXHAUSTED);
`ifdef PHASE_WATCHDOG_EN
        timeout_err      = (state == TIMEOUT);
`else
        timeout_err      = 1'b0;
`endif
    end

endmodule

// File: doc/rc4_phase_sequencer.md
# rc4_phase_sequencer

Parametrised top-level sequencer for the RC4 key-search datapath. It steps through NUM_PHASES worker FSMs in order, for example s[i]=i init, shuffle, second shuffle, S read-out and decrypt. After each failed decrypt it advances a candidate key and reruns the phases until a key validates or the key range is exhausted. It owns the phase start/reset strobes and the candidate key; the memory bus mux is steered from `phase_idx`.

## Interface
Parameters:
- NUM_PHASES, 5, number of worker phases (2..8)
- PHASE_MASK, 5'b11111, bit k=0 skips phase k entirely (at least one bit set)
- KEY_WIDTH, 24, candidate key width
- KEY_END, 24'h3FFFFF, last key tried (inclusive)
- TIMEOUT_CYCLES, 65535, per-phase watchdog limit (used only with watchdog compiled in)

Ports (PW = $clog2(NUM_PHASES)):
- CLOCK_50  in  1  sole clock
- reset  in  1  synchronous, active-high
- restart  in  1  start/restart search from `key_start` (switch change)
- key_start  in  KEY_WIDTH  first key; sampled only in CLEAR
- phase_done  in  NUM_PHASES  done flag per phase, level or pulse
- decrypt_valid  in  1  message all-printable; meaningful with last enabled phase's done
- reset_all  out  1  resets all worker FSMs
- phase_start  out  NUM_PHASES  one-hot start level to current phase
- phase_idx  out  PW  index of current/last phase
- candidate_key  out  KEY_WIDTH  key under test
- busy  out  1  search in progress
- key_found  out  1  sticky success
- search_exhausted  out  1  sticky failure, range done
- timeout_err  out  1  sticky watchdog trip

## Operation
States:
- IDLE
- CLEAR
- LAUNCH
- RUN
- NEXT_KEY
- FOUND
- EXHAUSTED
- TIMEOUT

Transitions:
- reset -> IDLE; reset has priority over everything. restart (not reset) -> CLEAR from any state, including mid-phase.
- IDLE: wait for restart.
- CLEAR: reset_all=1; load candidate_key<=key_start; clear sticky flags; phase_idx<=first enabled phase -> LAUNCH.
- LAUNCH: phase_start[phase_idx]=1; phase_done ignored -> RUN.
- RUN: phase_start[phase_idx]=1; wait phase_done[phase_idx]. Other done bits are ignored.
  - If it is not the last enabled phase: phase_idx<=next enabled index (skips masked bits) -> LAUNCH.
  - Last enabled phase, decrypt_valid=1 -> FOUND.
  - Last enabled phase, decrypt_valid=0 and candidate_key==KEY_END -> EXHAUSTED.
  - Otherwise -> NEXT_KEY.
- NEXT_KEY: reset_all=1; candidate_key<=candidate_key+1 (no wrap is possible since KEY_END bounds it); phase_idx<=first enabled -> LAUNCH.
- FOUND / EXHAUSTED / TIMEOUT: terminal. The matching sticky flag is 1, busy=0, all starts 0; candidate_key holds. Exit only via restart or reset.

Other rules:
- busy=1 in CLEAR, LAUNCH, RUN and NEXT_KEY.
- key_start > KEY_END: one full attempt runs, then EXHAUSTED on failure.

## Timing
- Reset values (cycle after reset sampled high):
  - state IDLE
  - all outputs 0 except candidate_key=0 and phase_idx=0
- restart sampled at cycle t: CLEAR at t+1, LAUNCH at t+2, RUN at t+3.
- Phase handoff: done sampled in RUN at cycle r -> LAUNCH of the next phase at r+1. There is a minimum one-cycle gap, and phase_start stays continuous across LAUNCH→RUN.
- Key retry: failing done at r -> NEXT_KEY at r+1 (reset_all pulse, key+1 visible at r+2), LAUNCH phase 0 at r+2.
- Minimum attempt length: 2 cycles per enabled phase + 1.
- Same-cycle done and restart: restart wins; the done is discarded.
- All outputs are registered-state decodes; no combinational path from inputs to outputs.

## Configuration
- PHASE_WATCHDOG_EN defined:
  - A cycle counter clears in LAUNCH and counts in RUN.
  - If it reaches TIMEOUT_CYCLES without phase_done[phase_idx] -> TIMEOUT: timeout_err=1, phase_idx frozen at the hung phase.
  - Done arriving on the same cycle as the limit wins over the timeout.
- Undefined: no counter. RUN waits indefinitely, timeout_err is tied 0, and the TIMEOUT state is unreachable.

## Test plan
- Reset: hold reset 2 cycles -> IDLE. All flags and phase_start are 0, candidate_key=0, and reset_all=0.
- Single attempt, success: NUM_PHASES=5, key_start=0x10. Each done fires 3 cycles after its start; last done has decrypt_valid=1 -> phases 0..4 launched in order, key_found=1, candidate_key=0x10, busy=0.
- Retry and exhaustion: KEY_END=0x12, key_start=0x10, decrypt_valid always 0 -> three attempts with a reset_all pulse between each, keys 0x10,0x11,0x12, then search_exhausted=1.
- Mask skip: PHASE_MASK=5'b10101 -> only phase_start[0], [2], [4] ever assert, and phase_idx goes 0,2,4.
- Mid-phase restart: restart during RUN phase 2 with key_start=0x55 -> reset_all at t+1, phase_start[0] at t+2, candidate_key=0x55. Same-cycle phase_done[2] has no effect.
- Watchdog (PHASE_WATCHDOG_EN, TIMEOUT_CYCLES=100): phase 1 never completes -> timeout_err=1 exactly 100 RUN cycles after phase 1's LAUNCH, phase_idx=1. Without the macro, the block is still busy after 10000 cycles.
